// File: rtl/softmax_seq_if.sv
// ============================================================================
// Module   : softmax_seq_if
// Purpose  : Vector-in / probability-vector-out handshake bundle for softmax_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface softmax_seq_if #(
   parameter int DATA_WIDTH = 8,
   parameter int INPUT_NUM  = 10,
   parameter int OUT_WIDTH  = 8,
   parameter int LEN_WIDTH  = $clog2(INPUT_NUM + 1)
) ();
   logic [DATA_WIDTH*INPUT_NUM-1:0] in_data;
   logic [LEN_WIDTH-1:0]            vec_len;
   logic                            in_valid;
   logic                            in_ready;
   logic [OUT_WIDTH*INPUT_NUM-1:0]  out_data;
   logic                            out_valid;
   logic                            out_ready;

   modport master (
      output in_data, vec_len, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, vec_len, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

`default_nettype wire

// File: rtl/softmax_seq.sv
// ============================================================================
// Module   : softmax_seq
// Purpose  : Sequential base-2 softmax: serial max scan, exponent/accumulate,
//            then a shared restoring divider producing Q0.OUT_WIDTH lanes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module softmax_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int INPUT_NUM  = 10,
   parameter int OUT_WIDTH  = 8,
   parameter int EXP_WIDTH  = 16,
   parameter int LEN_WIDTH  = $clog2(INPUT_NUM + 1)
) (
   input  logic          clk_p,
   input  logic          rst_n,
   softmax_seq_if.slave  bus,
   output logic          busy
);

   localparam int c_sumWidth = EXP_WIDTH + $clog2(INPUT_NUM);
   localparam int c_cntWidth = $clog2(OUT_WIDTH + 1);
   localparam logic [LEN_WIDTH-1:0]  c_maxLen  = LEN_WIDTH'(INPUT_NUM);
   localparam logic [c_cntWidth-1:0] c_lastBit = c_cntWidth'(OUT_WIDTH);
   localparam logic [EXP_WIDTH-1:0]  c_expOne  = {1'b1, {(EXP_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MAX    = 3'd1,
      EXPSUM = 3'd2,
      DIV    = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [DATA_WIDTH*INPUT_NUM-1:0] r_data;
   logic [OUT_WIDTH*INPUT_NUM-1:0]  r_outData;
   logic [LEN_WIDTH-1:0]            r_len;
   logic [LEN_WIDTH-1:0]            r_idx;
   logic [c_cntWidth-1:0]           r_bitCnt;
   logic signed [DATA_WIDTH-1:0]    r_max;
   logic [EXP_WIDTH-1:0]            r_exp [INPUT_NUM];
   logic [c_sumWidth-1:0]           r_sum;
   logic [c_sumWidth-1:0]           r_rem;
   logic [OUT_WIDTH-1:0]            r_quot;

   logic                            w_inReady;
   logic                            w_outValid;
   logic                            w_accept;
   logic                            w_lastLane;
   logic                            w_lastBit;
   logic [LEN_WIDTH-1:0]            w_effLen;
   logic signed [DATA_WIDTH-1:0]    w_lane;
   logic [DATA_WIDTH:0]             w_diff;
   logic [EXP_WIDTH-1:0]            w_expTerm;
   logic [c_sumWidth-1:0]           w_expExt;
   logic [c_sumWidth:0]             w_remCand;
   logic [c_sumWidth:0]             w_remNext;
   logic                            w_ge;
   logic [OUT_WIDTH:0]              w_quotFull;
   logic [OUT_WIDTH-1:0]            w_quotSat;

   assign w_accept   = bus.in_valid && w_inReady;
   assign w_lastLane = (r_idx == r_len - 1'b1);
   assign w_lastBit  = (r_bitCnt == c_lastBit);
   assign w_effLen   = ((bus.vec_len == '0) || (bus.vec_len > c_maxLen)) ? c_maxLen : bus.vec_len;

   // --------------------------------------------------------------------
   // Datapath combinational terms
   // --------------------------------------------------------------------
   always_comb begin
      w_lane    = r_data[DATA_WIDTH*r_idx +: DATA_WIDTH];
      // max - x is never negative, so the sign-extended difference is its magnitude
      w_diff    = {r_max[DATA_WIDTH-1], r_max} - {w_lane[DATA_WIDTH-1], w_lane};
      w_expTerm = (int'(w_diff) >= EXP_WIDTH) ? '0 : (c_expOne >> w_diff);
      w_expExt  = '0;
      w_expExt[EXP_WIDTH-1:0] = w_expTerm;

      // First divider step loads e_i (integer quotient bit); later steps shift the remainder
      w_remCand = '0;
      if (r_bitCnt == '0) begin
         w_remCand[EXP_WIDTH-1:0] = r_exp[r_idx];
      end else begin
         w_remCand = {r_rem, 1'b0};
      end
      w_ge       = (w_remCand >= {1'b0, r_sum});
      w_remNext  = w_ge ? (w_remCand - {1'b0, r_sum}) : w_remCand;
      w_quotFull = {r_quot, w_ge};
      w_quotSat  = w_quotFull[OUT_WIDTH] ? '1 : w_quotFull[OUT_WIDTH-1:0];
   end

   // --------------------------------------------------------------------
   // Control FSM
   // --------------------------------------------------------------------
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      w_outValid  = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            busy      = 1'b0;
            w_inReady = rst_n;
            if (bus.in_valid) w_nextState = MAX;
         end
         MAX:    if (w_lastLane) w_nextState = EXPSUM;
         EXPSUM: if (w_lastLane) w_nextState = DIV;
         DIV:    if (w_lastLane && w_lastBit) w_nextState = DONE;
         DONE: begin
            w_outValid = 1'b1;
            if (bus.out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // --------------------------------------------------------------------
   // Datapath registers
   // --------------------------------------------------------------------
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_outData <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_bitCnt  <= '0;
         r_max     <= '0;
         r_sum     <= '0;
         r_rem     <= '0;
         r_quot    <= '0;
         for (int i = 0; i < INPUT_NUM; i++) r_exp[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_data   <= bus.in_data;
                  r_len    <= w_effLen;
                  r_idx    <= '0;
                  r_bitCnt <= '0;
                  r_max    <= '0;
                  r_sum    <= '0;
                  for (int i = 0; i < INPUT_NUM; i++) begin
                     if (i >= int'(w_effLen)) r_outData[OUT_WIDTH*i +: OUT_WIDTH] <= '0;
                  end
               end
            end
            MAX: begin
               if ((r_idx == '0) || (w_lane > r_max)) r_max <= w_lane;
               r_idx <= w_lastLane ? '0 : r_idx + 1'b1;
            end
            EXPSUM: begin
               r_exp[r_idx] <= w_expTerm;
               r_sum        <= r_sum + w_expExt;
               r_idx        <= w_lastLane ? '0 : r_idx + 1'b1;
            end
            DIV: begin
               r_rem  <= w_remNext[c_sumWidth-1:0];
               r_quot <= w_quotFull[OUT_WIDTH-1:0];
               if (w_lastBit) begin
                  r_outData[OUT_WIDTH*r_idx +: OUT_WIDTH] <= w_quotSat;
                  r_bitCnt <= '0;
                  r_idx    <= w_lastLane ? '0 : r_idx + 1'b1;
               end else begin
                  r_bitCnt <= r_bitCnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = w_outValid;
   assign bus.out_data  = r_outData;

endmodule

`default_nettype wire

// File: tb/tb_softmax_seq.sv
// ============================================================================
// Module   : tb_softmax_seq
// Purpose  : Scoreboard bench for softmax_seq with N=4, DW=8, OW=8, EW=16.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_softmax_seq;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int OW = 8;
   localparam int EW = 16;
   localparam int LW = $clog2(N + 1);

   typedef struct {
      logic [OW*N-1:0] outv;
      int              lat;
   } exp_t;

   logic clk_p;
   logic rst_n;
   logic busy;
   int   nTests;
   int   nFail;
   exp_t sb [$];

   softmax_seq_if #(.DATA_WIDTH(DW), .INPUT_NUM(N), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) ifc ();

   softmax_seq #(
      .DATA_WIDTH (DW),
      .INPUT_NUM  (N),
      .OUT_WIDTH  (OW),
      .EXP_WIDTH  (EW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk_p (clk_p),
      .rst_n (rst_n),
      .bus   (ifc.slave),
      .busy  (busy)
   );

   initial clk_p = 1'b0;
   always #5 clk_p = ~clk_p;

   task automatic chkVal(input string tag, input logic [63:0] got, input logic [63:0] expv);
      nTests++;
      if (got !== expv) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic logic [DW*N-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [DW-1:0] la, lb, lc, ld;
      la = DW'(a); lb = DW'(b); lc = DW'(c); ld = DW'(d);
      return {ld, lc, lb, la};
   endfunction

   // Reference model straight from the softmax definition
   function automatic exp_t model(input logic [DW*N-1:0] d, input int vlen);
      exp_t r;
      int L, mx, xi, dd;
      longint ev [N];
      longint s, q;
      logic signed [DW-1:0] x;
      L  = (vlen == 0 || vlen > N) ? N : vlen;
      mx = 0;
      s  = 0;
      for (int i = 0; i < L; i++) begin
         x  = d[DW*i +: DW];
         xi = int'(x);
         if (i == 0 || xi > mx) mx = xi;
      end
      for (int i = 0; i < L; i++) begin
         x  = d[DW*i +: DW];
         dd = mx - int'(x);
         ev[i] = (dd >= EW) ? 0 : ((longint'(1) << (EW - 1)) >> dd);
         s += ev[i];
      end
      r.outv = '0;
      for (int i = 0; i < L; i++) begin
         q = (ev[i] << OW) / s;
         if (q > (longint'(1) << OW) - 1) q = (longint'(1) << OW) - 1;
         r.outv[OW*i +: OW] = q[OW-1:0];
      end
      r.lat = L * (OW + 3) + 1;
      return r;
   endfunction

   task automatic sendVec(input logic [DW*N-1:0] d, input int len, output int waited);
      sb.push_back(model(d, len));
      ifc.in_data  = d;
      ifc.vec_len  = LW'(len);
      ifc.in_valid = 1'b1;
      waited = 0;
      while (!ifc.in_ready && waited < 200) begin
         @(negedge clk_p);
         waited++;
      end
      if (waited >= 200) chkVal("acceptTimeout", 64'(waited), 0);
      @(posedge clk_p);
      #1;
      ifc.in_valid = 1'b0;
      chkVal("busyAfterAccept", 64'(busy), 1);
   endtask

   task automatic waitResult(input int holdCycles);
      exp_t e;
      int   cnt;
      cnt = 0;
      while (!ifc.out_valid && cnt < 2000) begin
         @(negedge clk_p);
         cnt++;
      end
      if (sb.size() == 0) begin
         chkVal("sbEmpty", 1, 0);
      end else begin
         e = sb.pop_front();
         chkVal("latency", 64'(cnt), 64'(e.lat));
         for (int i = 0; i < N; i++) chkVal($sformatf("lane%0d", i), 64'(ifc.out_data[OW*i +: OW]), 64'(e.outv[OW*i +: OW]));
         for (int k = 0; k < holdCycles; k++) begin
            ifc.in_valid = k[0];
            ifc.in_data  = pack4(k, -k, 100, -100);
            ifc.vec_len  = LW'(k);
            @(negedge clk_p);
            chkVal("holdValid", 64'(ifc.out_valid), 1);
            chkVal("holdReady", 64'(ifc.in_ready), 0);
            chkVal("holdData", 64'(ifc.out_data), 64'(e.outv));
         end
      end
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      @(posedge clk_p);
      #1;
      ifc.out_ready = 1'b0;
      chkVal("validDrop", 64'(ifc.out_valid), 0);
      chkVal("readyAfterHs", 64'(ifc.in_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      nTests = 0;
      nFail  = 0;
      rst_n         = 1'b0;
      ifc.in_data   = '0;
      ifc.vec_len   = '0;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      #12;
      chkVal("rstValid", 64'(ifc.out_valid), 0);
      chkVal("rstData", 64'(ifc.out_data), 0);
      chkVal("rstBusy", 64'(busy), 0);
      @(negedge clk_p);
      rst_n = 1'b1;
      #1;
      chkVal("rstReady", 64'(ifc.in_ready), 1);

      sendVec(pack4(5, 5, 5, 5), 4, w);        waitResult(0);
      sendVec(pack4(3, 2, 1, 0), 4, w);        waitResult(0);
      sendVec(pack4(127, -128, 0, 0), 4, w);   waitResult(0);
      sendVec(pack4(-7, 9, 9, 9), 1, w);       waitResult(0);
      sendVec(pack4(0, -1, 9, 9), 2, w);       waitResult(0);
      sendVec(pack4(1, 0, 0, 0), 7, w);        waitResult(0);

      // Backpressure with ignored input pulses, then a back-to-back vector
      sendVec(pack4(3, 2, 1, 0), 0, w);        waitResult(20);
      sendVec(pack4(-3, 4, -5, 6), 4, w);
      chkVal("b2bAccept", 64'(w), 0);
      waitResult(0);

      // Abort in the middle of the divide phase
      sendVec(pack4(3, 2, 1, 0), 4, w);
      repeat (13) @(negedge clk_p);
      rst_n = 1'b0;
      #1;
      chkVal("abortValid", 64'(ifc.out_valid), 0);
      chkVal("abortData", 64'(ifc.out_data), 0);
      chkVal("abortBusy", 64'(busy), 0);
      void'(sb.pop_back());
      repeat (2) @(negedge clk_p);
      rst_n = 1'b1;
      #1;
      chkVal("abortReady", 64'(ifc.in_ready), 1);
      sendVec(pack4(5, 5, 5, 5), 4, w);        waitResult(0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/softmax_seq.md
Name: softmax_seq

Overview:
- Parametrised, handshaked successor to the team's vector softmax engine; sits between the attention-score datapath and the weighting stage.
- Accepts a vector of up to INPUT_NUM signed integer logits with a run-time active length.
- Computes base-2 softmax with max subtraction: out_i = 2^(x_i-max) / sum_j 2^(x_j-max), as unsigned Q0.OUT_WIDTH.
- Uses a serial max scan, a serial exponent/accumulate pass and a shared bit-serial divider; ready/valid on both sides with backpressure.

Parameters:
DATA_WIDTH, 8, width of each signed two's-complement input logit
INPUT_NUM, 10, maximum vector length (number of lanes)
OUT_WIDTH, 8, output fraction bits (unsigned Q0.OUT_WIDTH)
EXP_WIDTH, 16, width of each exponent term; the max element maps to 2^(EXP_WIDTH-1)
LEN_WIDTH, $clog2(INPUT_NUM+1), width of vec_len

Ports:
clk_p  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
in_data  in  DATA_WIDTH*INPUT_NUM  logits; element i at [DATA_WIDTH*i +: DATA_WIDTH]
vec_len  in  LEN_WIDTH  active length L; sampled with in_data
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector (high only in IDLE)
out_data  out  OUT_WIDTH*INPUT_NUM  probabilities; element i at [OUT_WIDTH*i +: OUT_WIDTH]
out_valid  out  1  out_data valid; held until out_ready
out_ready  in  1  downstream accepts out_data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; out_data=0; busy=0; in_ready=1 once rst_n=1; all counters, max, sum and divider registers =0. Reset asserted mid-operation aborts immediately; the partial vector is discarded.
- Accept: in_valid&&in_ready at an edge latches in_data and L. vec_len==0 or >INPUT_NUM -> L=INPUT_NUM. Lanes i>=L are excluded from max and sum; their outputs are 0.
- State MAX, L cycles: one lane per cycle; max=max(max,x_i), signed compare; first lane loads max directly.
- State EXPSUM, L cycles: d=max-x_i as unsigned DATA_WIDTH+1 bits. e_i=2^(EXP_WIDTH-1)>>d, and e_i=0 when d>=EXP_WIDTH. e_i is stored per lane. S accumulates e_i in EXP_WIDTH+$clog2(INPUT_NUM) bits without overflow. S>=2^(EXP_WIDTH-1) always, so there is never a divide-by-zero.
- State DIV, OUT_WIDTH+1 cycles per active lane, lanes 0..L-1 in order: restoring shift-subtract produces one quotient bit per cycle, q_i=floor(e_i*2^OUT_WIDTH/S). Because q_i<=2^OUT_WIDTH, q_i=2^OUT_WIDTH saturates to 2^OUT_WIDTH-1. Each result is written to its lane of out_data when its last bit completes.
- State DONE: out_valid=1; out_data stable; in_ready=0. out_valid&&out_ready -> IDLE, out_valid=0 on the same edge. out_data holds its value until the next result is written.
- Latency: from the accept edge to the first edge with out_valid=1 = L*(OUT_WIDTH+3)+1 cycles, independent of data.
- Throughput: no overlap; the next vector is accepted no earlier than the cycle after the output handshake.
- in_valid while busy is ignored; no in_data change is captured. out_ready outside DONE is ignored.
- Lane outputs i>=L are cleared to 0 at accept.

Test Plan:
- Params N=4, DW=8, OW=8, EW=16; in=[5,5,5,5], L=4 -> out=[64,64,64,64]; out_valid exactly 45 cycles after accept.
- in=[3,2,1,0] (lane0 first), L=4 -> e=[32768,16384,8192,4096], S=61440, out=[136,68,34,17].
- in=[127,-128,0,0], L=4 -> d=255 and 127 give e=0 -> out=[255,0,0,0] (saturation); separately L=1, in=[-7,x,x,x] -> out=[255,0,0,0], latency 12 cycles.
- vec_len=2, in=[0,-1,9,9] -> lanes 2,3 excluded -> out=[170,85,0,0]; vec_len=0 behaves as L=4.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data and out_valid stable, in_ready=0, and in_valid pulses ignored. Release -> one handshake, in_ready=1 next cycle, a back-to-back vector is accepted.
- Pull rst_n low during DIV -> out_valid=0 and out_data=0 asynchronously, busy=0. After release, a new vector [5,5,5,5] yields [64,64,64,64].
